// File: rtl/axi4l_arb_pkg.sv
// Shared types for the two-requester AXI4-Lite arbiter.
`timescale 1ns/1ps
package axi4l_arb_pkg;
   localparam int unsigned AddrW = 32;
   localparam int unsigned DataW = 32;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_RESP
   } arb_state_e;

   typedef logic port_idx_t;
endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle; "master" drives addresses/data, "slave" drives readies/responses.
`timescale 1ns/1ps
interface axi4l_if;
   import axi4l_arb_pkg::*;

   logic [AddrW-1:0]   awaddr;
   logic [2:0]         awprot;
   logic               awvalid;
   logic               awready;
   logic [DataW-1:0]   wdata;
   logic [DataW/8-1:0] wstrb;
   logic               wvalid;
   logic               wready;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;
   logic [AddrW-1:0]   araddr;
   logic [2:0]         arprot;
   logic               arvalid;
   logic               arready;
   logic [DataW-1:0]   rdata;
   logic [1:0]         rresp;
   logic               rvalid;
   logic               rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way selector: round-robin against last_grant, or fixed priority.
`timescale 1ns/1ps
module rr_arb2
   import axi4l_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_idx_t  last_grant,
   input  logic       fixed_prio,
   input  port_idx_t  prio_port,
   output logic       gnt_valid,
   output port_idx_t  gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = req[1];
      if (req == 2'b11) begin
         gnt_idx = fixed_prio ? prio_port : ~last_grant;
      end
   end

endmodule

// File: rtl/axi4l_arbiter_2to1.sv
// Shares one AXI4-Lite master port between two requesters, one transaction at a time.
//   state   | meaning
//   IDLE    | arbitrate; winner's AR/AW accepted this cycle
//   RD_ADDR | m.arvalid with captured read address
//   RD_DATA | R channel passed through to the granted port
//   WR_ADDR | AW issued and W captured/issued, independently
//   WR_RESP | B channel passed through to the granted port
`timescale 1ns/1ps
module axi4l_arbiter_2to1
   import axi4l_arb_pkg::*;
#(
   parameter bit          FixedPrio = 1'b0,
   parameter int unsigned PrioPort  = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   axi4l_if.slave    s0,
   axi4l_if.slave    s1,
   axi4l_if.master   m,
   output logic      busy,
   output port_idx_t grant
);

   localparam port_idx_t PrioIdx = (PrioPort != 0) ? 1'b1 : 1'b0;

   arb_state_e         state_q, state_d;
   port_idx_t          grant_q, grant_d;
   port_idx_t          last_grant_q, last_grant_d;
   logic               aw_done_q, aw_done_d;
   logic               w_done_q, w_done_d;
   logic               w_cap_q, w_cap_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic [2:0]         prot_q, prot_d;
   logic [DataW-1:0]   wdata_q, wdata_d;
   logic [DataW/8-1:0] wstrb_q, wstrb_d;

   logic       gnt_valid;
   port_idx_t  gnt_idx;
   port_idx_t  cur_idx;

   rr_arb2 u_rr_arb2 (
      .req        ({s1.arvalid | s1.awvalid, s0.arvalid | s0.awvalid}),
      .last_grant (last_grant_q),
      .fixed_prio (FixedPrio),
      .prio_port  (PrioIdx),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   // The live arbiter decision steers the ports only in IDLE; afterwards the registered grant does.
   assign cur_idx = (state_q == IDLE) ? gnt_idx : grant_q;

   logic               sel_arvalid, sel_wvalid, sel_rready, sel_bready;
   logic [AddrW-1:0]   sel_araddr, sel_awaddr;
   logic [2:0]         sel_arprot, sel_awprot;
   logic [DataW-1:0]   sel_wdata;
   logic [DataW/8-1:0] sel_wstrb;

   assign sel_arvalid = cur_idx ? s1.arvalid : s0.arvalid;
   assign sel_araddr  = cur_idx ? s1.araddr  : s0.araddr;
   assign sel_arprot  = cur_idx ? s1.arprot  : s0.arprot;
   assign sel_awaddr  = cur_idx ? s1.awaddr  : s0.awaddr;
   assign sel_awprot  = cur_idx ? s1.awprot  : s0.awprot;
   assign sel_wvalid  = cur_idx ? s1.wvalid  : s0.wvalid;
   assign sel_wdata   = cur_idx ? s1.wdata   : s0.wdata;
   assign sel_wstrb   = cur_idx ? s1.wstrb   : s0.wstrb;
   assign sel_rready  = cur_idx ? s1.rready  : s0.rready;
   assign sel_bready  = cur_idx ? s1.bready  : s0.bready;

   logic sel_arready, sel_awready, sel_wready, sel_rvalid, sel_bvalid;

   always_comb begin
      sel_arready = 1'b0;
      sel_awready = 1'b0;
      sel_wready  = 1'b0;
      sel_rvalid  = 1'b0;
      sel_bvalid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               sel_arready = sel_arvalid;
               sel_awready = ~sel_arvalid;
            end
         end
         WR_ADDR: sel_wready = ~w_cap_q;
         RD_DATA: sel_rvalid = m.rvalid;
         WR_RESP: sel_bvalid = m.bvalid;
         default: ;
      endcase
   end

   assign s0.arready = sel_arready & (cur_idx == 1'b0);
   assign s0.awready = sel_awready & (cur_idx == 1'b0);
   assign s0.wready  = sel_wready  & (cur_idx == 1'b0);
   assign s0.rvalid  = sel_rvalid  & (cur_idx == 1'b0);
   assign s0.bvalid  = sel_bvalid  & (cur_idx == 1'b0);
   assign s1.arready = sel_arready & (cur_idx == 1'b1);
   assign s1.awready = sel_awready & (cur_idx == 1'b1);
   assign s1.wready  = sel_wready  & (cur_idx == 1'b1);
   assign s1.rvalid  = sel_rvalid  & (cur_idx == 1'b1);
   assign s1.bvalid  = sel_bvalid  & (cur_idx == 1'b1);

   assign s0.rdata = m.rdata;
   assign s0.rresp = m.rresp;
   assign s0.bresp = m.bresp;
   assign s1.rdata = m.rdata;
   assign s1.rresp = m.rresp;
   assign s1.bresp = m.bresp;

   logic m_awvalid, m_wvalid;

   assign m_awvalid = (state_q == WR_ADDR) & ~aw_done_q;
   assign m_wvalid  = (state_q == WR_ADDR) & w_cap_q & ~w_done_q;

   assign m.arvalid = (state_q == RD_ADDR);
   assign m.araddr  = addr_q;
   assign m.arprot  = prot_q;
   assign m.awvalid = m_awvalid;
   assign m.awaddr  = addr_q;
   assign m.awprot  = prot_q;
   assign m.wvalid  = m_wvalid;
   assign m.wdata   = wdata_q;
   assign m.wstrb   = wstrb_q;
   assign m.rready  = (state_q == RD_DATA) & sel_rready;
   assign m.bready  = (state_q == WR_RESP) & sel_bready;

   assign busy  = (state_q != IDLE);
   assign grant = grant_q;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      w_cap_d      = w_cap_q;
      addr_d       = addr_q;
      prot_d       = prot_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               grant_d = gnt_idx;
               if (sel_arvalid) begin
                  addr_d  = sel_araddr;
                  prot_d  = sel_arprot;
                  state_d = RD_ADDR;
               end else begin
                  addr_d  = sel_awaddr;
                  prot_d  = sel_awprot;
                  state_d = WR_ADDR;
               end
            end
         end
         RD_ADDR: begin
            if (m.arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (m.rvalid & sel_rready) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
         WR_ADDR: begin
            if (m_awvalid & m.awready) aw_done_d = 1'b1;
            if (sel_wvalid & ~w_cap_q) begin
               w_cap_d = 1'b1;
               wdata_d = sel_wdata;
               wstrb_d = sel_wstrb;
            end
            if (m_wvalid & m.wready) w_done_d = 1'b1;
            if (aw_done_d & w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (m.bvalid & sel_bready) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               w_cap_d      = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         w_cap_q      <= 1'b0;
         addr_q       <= '0;
         prot_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         w_cap_q      <= w_cap_d;
         addr_q       <= addr_d;
         prot_q       <= prot_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
      end
   end

endmodule

// File: tb/tb_axi4l_arbiter_2to1.sv
// Directed bench: a round-robin instance with a scripted downstream slave, plus a fixed-priority instance.
`timescale 1ns/1ps
module tb_axi4l_arbiter_2to1;
   import axi4l_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic      busy_a, busy_b;
   port_idx_t grant_a, grant_b;

   axi4l_if s0a ();
   axi4l_if s1a ();
   axi4l_if ma ();
   axi4l_if s0b ();
   axi4l_if s1b ();
   axi4l_if mb ();

   axi4l_arbiter_2to1 #(.FixedPrio(1'b0), .PrioPort(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .s0(s0a), .s1(s1a), .m(ma), .busy(busy_a), .grant(grant_a)
   );

   axi4l_arbiter_2to1 #(.FixedPrio(1'b1), .PrioPort(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .s0(s0b), .s1(s1b), .m(mb), .busy(busy_b), .grant(grant_b)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        port;
      logic        is_wr;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_ar_q[$];
   logic [31:0] mem [bit [31:0]];

   int          rd_lat = 2;
   int          aw_lat = 0;
   int          w_lat = 0;
   logic [1:0]  rd_resp = 2'b00;
   logic [1:0]  wr_resp = 2'b00;

   int          cyc = 0;
   int          aw_cnt = 0, w_cnt = 0, aw_t = 0, w_t = 0;
   logic [31:0] aw_addr_seen = '0, w_data_seen = '0;
   logic [3:0]  w_strb_seen = '0;
   logic        s1_seen = 1'b0;
   logic        both_active = 1'b0;
   int          cnt0_b = 0, cnt1_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic got_resp(input logic port, input logic is_wr, input logic [31:0] data,
                           input logic [1:0] resp);
      exp_t e;
      chk("resp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("resp_port", 32'(port), 32'(e.port));
         chk("resp_kind", 32'(is_wr), 32'(e.is_wr));
         if (!is_wr) chk("resp_rdata", data, e.data);
         chk("resp_code", 32'(resp), 32'(e.resp));
         chk("resp_grant", 32'(grant_a), 32'(e.port));
         chk("resp_busy", 32'(busy_a), 1);
      end
   endtask

   // Response scoreboard and m-side observers for instance A
   always @(negedge clk) begin
      if (rst_n) begin
         if (s0a.rvalid && s0a.rready) got_resp(1'b0, 1'b0, s0a.rdata, s0a.rresp);
         if (s1a.rvalid && s1a.rready) got_resp(1'b1, 1'b0, s1a.rdata, s1a.rresp);
         if (s0a.bvalid && s0a.bready) got_resp(1'b0, 1'b1, s0a.rdata, s0a.bresp);
         if (s1a.bvalid && s1a.bready) got_resp(1'b1, 1'b1, s1a.rdata, s1a.bresp);
         if (ma.arvalid && ma.arready) begin
            chk("ar_expected", 32'(exp_ar_q.size() != 0), 1);
            if (exp_ar_q.size() != 0) chk("ar_addr", ma.araddr, exp_ar_q.pop_front());
         end
         if (ma.awvalid && ma.awready) begin
            aw_cnt++;
            aw_t = cyc;
            aw_addr_seen = ma.awaddr;
         end
         if (ma.wvalid && ma.wready) begin
            w_cnt++;
            w_t = cyc;
            w_data_seen = ma.wdata;
            w_strb_seen = ma.wstrb;
         end
         if (s1a.arready | s1a.awready | s1a.wready | s1a.rvalid | s1a.bvalid) s1_seen = 1'b1;
         if ((s0a.arready | s0a.awready | s0a.wready | s0a.rvalid | s0a.bvalid) &&
             (s1a.arready | s1a.awready | s1a.wready | s1a.rvalid | s1a.bvalid)) both_active = 1'b1;
         if (s0b.arvalid && s0b.arready) cnt0_b++;
         if (s1b.arvalid && s1b.arready) cnt1_b++;
      end
   end

   // Downstream slave for instance A with programmable latencies
   initial begin : slave_a
      logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
      logic r_pend, aw_got, w_got;
      int   r_cnt, aw_wait, w_wait;
      logic [31:0] ar_addr;
      ma.arready = 1'b0; ma.rvalid = 1'b0; ma.rdata = '0; ma.rresp = '0;
      ma.awready = 1'b0; ma.wready = 1'b0; ma.bvalid = 1'b0; ma.bresp = '0;
      r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      r_cnt = 0; aw_wait = 0; w_wait = 0; ar_addr = '0;
      forever begin
         @(negedge clk);
         ar_hs = ma.arvalid & ma.arready;
         r_hs  = ma.rvalid & ma.rready;
         aw_hs = ma.awvalid & ma.awready;
         w_hs  = ma.wvalid & ma.wready;
         b_hs  = ma.bvalid & ma.bready;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            ma.arready = 1'b0; ma.rvalid = 1'b0; ma.awready = 1'b0; ma.wready = 1'b0; ma.bvalid = 1'b0;
            r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0;
            continue;
         end
         ma.arready = ma.arvalid;
         if (r_hs) ma.rvalid = 1'b0;
         if (ar_hs) begin
            ar_addr = ma.araddr;
            r_pend = 1'b1;
            r_cnt = rd_lat;
         end
         if (r_pend) begin
            if (r_cnt == 0) begin
               ma.rvalid = 1'b1;
               ma.rdata = mem.exists(ar_addr) ? mem[ar_addr] : 32'hBAD0_0000;
               ma.rresp = rd_resp;
               r_pend = 1'b0;
            end else begin
               r_cnt--;
            end
         end
         if (aw_hs) aw_got = 1'b1;
         if (w_hs) w_got = 1'b1;
         if (ma.awvalid && !ma.awready) aw_wait++;
         else if (!ma.awvalid) aw_wait = 0;
         if (ma.wvalid && !ma.wready) w_wait++;
         else if (!ma.wvalid) w_wait = 0;
         ma.awready = ma.awvalid && (aw_wait >= aw_lat);
         ma.wready  = ma.wvalid && (w_wait >= w_lat);
         if (b_hs) ma.bvalid = 1'b0;
         if (aw_got && w_got && !ma.bvalid) begin
            ma.bvalid = 1'b1;
            ma.bresp = wr_resp;
            aw_got = 1'b0;
            w_got = 1'b0;
         end
      end
   end

   // Always-ready read-only slave for instance B
   initial begin : slave_b
      logic ar_hs, r_hs;
      mb.arready = 1'b0; mb.rvalid = 1'b0; mb.rdata = '0; mb.rresp = '0;
      mb.awready = 1'b0; mb.wready = 1'b0; mb.bvalid = 1'b0; mb.bresp = '0;
      forever begin
         @(negedge clk);
         ar_hs = mb.arvalid & mb.arready;
         r_hs  = mb.rvalid & mb.rready;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mb.arready = 1'b0;
            mb.rvalid = 1'b0;
            continue;
         end
         mb.arready = mb.arvalid;
         if (r_hs) mb.rvalid = 1'b0;
         if (ar_hs) begin
            mb.rvalid = 1'b1;
            mb.rdata = 32'h0B0B_0000;
         end
      end
   end

   // One cycle for the requesters of A: valids drop right after their handshake edge
   task automatic tick();
      logic ar0, aw0, w0, ar1, aw1, w1;
      @(negedge clk);
      ar0 = s0a.arvalid & s0a.arready;
      aw0 = s0a.awvalid & s0a.awready;
      w0  = s0a.wvalid & s0a.wready;
      ar1 = s1a.arvalid & s1a.arready;
      aw1 = s1a.awvalid & s1a.awready;
      w1  = s1a.wvalid & s1a.wready;
      @(posedge clk);
      #1;
      if (ar0) s0a.arvalid = 1'b0;
      if (aw0) s0a.awvalid = 1'b0;
      if (w0)  s0a.wvalid = 1'b0;
      if (ar1) s1a.arvalid = 1'b0;
      if (aw1) s1a.awvalid = 1'b0;
      if (w1)  s1a.wvalid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || busy_a) && n < max_cyc) begin
         tick();
         n++;
      end
      chk(tag, 32'(exp_q.size() == 0 && !busy_a), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic read_s0(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
      mem[addr] = data;
      exp_ar_q.push_back(addr);
      exp_q.push_back('{port: 1'b0, is_wr: 1'b0, data: data, resp: resp});
      s0a.araddr = addr;
      s0a.arvalid = 1'b1;
   endtask

   task automatic read_s1(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
      mem[addr] = data;
      exp_ar_q.push_back(addr);
      exp_q.push_back('{port: 1'b1, is_wr: 1'b0, data: data, resp: resp});
      s1a.araddr = addr;
      s1a.arvalid = 1'b1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      s0a.araddr = '0; s0a.arprot = '0; s0a.arvalid = 1'b0; s0a.awaddr = '0; s0a.awprot = '0;
      s0a.awvalid = 1'b0; s0a.wdata = '0; s0a.wstrb = '0; s0a.wvalid = 1'b0; s0a.rready = 1'b1; s0a.bready = 1'b1;
      s1a.araddr = '0; s1a.arprot = '0; s1a.arvalid = 1'b0; s1a.awaddr = '0; s1a.awprot = '0;
      s1a.awvalid = 1'b0; s1a.wdata = '0; s1a.wstrb = '0; s1a.wvalid = 1'b0; s1a.rready = 1'b1; s1a.bready = 1'b1;
      s0b.araddr = '0; s0b.arprot = '0; s0b.arvalid = 1'b0; s0b.awaddr = '0; s0b.awprot = '0;
      s0b.awvalid = 1'b0; s0b.wdata = '0; s0b.wstrb = '0; s0b.wvalid = 1'b0; s0b.rready = 1'b1; s0b.bready = 1'b1;
      s1b.araddr = 32'h40; s1b.arprot = '0; s1b.arvalid = 1'b0; s1b.awaddr = '0; s1b.awprot = '0;
      s1b.awvalid = 1'b0; s1b.wdata = '0; s1b.wstrb = '0; s1b.wvalid = 1'b0; s1b.rready = 1'b1; s1b.bready = 1'b1;

      // Reset values
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_grant", 32'(grant_a), 0);
      chk("rst_m_arvalid", 32'(ma.arvalid), 0);
      chk("rst_m_awvalid", 32'(ma.awvalid), 0);
      chk("rst_m_wvalid", 32'(ma.wvalid), 0);
      chk("rst_m_rready", 32'(ma.rready), 0);
      chk("rst_m_bready", 32'(ma.bready), 0);
      chk("rst_s0_wready", 32'(s0a.wready), 0);
      chk("rst_busy_b", 32'(busy_b), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Single read from s0
      s1_seen = 1'b0;
      rd_lat = 2;
      read_s0(32'h0000_0080, 32'hDEAD_BEEF, 2'b00);
      wait_done("t1_done", 30);
      chk("t1_s1_no_ready", 32'(s1_seen), 0);
      chk("t1_grant_hold", 32'(grant_a), 0);

      // Simultaneous reads out of reset, twice
      do_reset();
      read_s0(32'h0000_0100, 32'h1111_0100, 2'b00);
      read_s1(32'h0000_0200, 32'h2222_0200, 2'b00);
      wait_done("t2_pair1_done", 60);
      read_s0(32'h0000_0104, 32'h1111_0104, 2'b00);
      read_s1(32'h0000_0204, 32'h2222_0204, 2'b00);
      wait_done("t2_pair2_done", 60);

      // s1 write: W arrives 3 cycles after AW, slave accepts W before AW
      aw_cnt = 0; w_cnt = 0;
      aw_lat = 8; w_lat = 0; wr_resp = 2'b00;
      exp_q.push_back('{port: 1'b1, is_wr: 1'b1, data: 32'h0, resp: 2'b00});
      s1a.awaddr = 32'h1000_0004;
      s1a.awvalid = 1'b1;
      tick(); tick(); tick();
      s1a.wdata = 32'h1234_5678;
      s1a.wstrb = 4'b0011;
      s1a.wvalid = 1'b1;
      wait_done("t3_done", 60);
      chk("t3_aw_count", 32'(aw_cnt), 1);
      chk("t3_w_count", 32'(w_cnt), 1);
      chk("t3_aw_addr", aw_addr_seen, 32'h1000_0004);
      chk("t3_w_data", w_data_seen, 32'h1234_5678);
      chk("t3_w_strb", 32'(w_strb_seen), 32'h3);
      chk("t3_w_before_aw", 32'(w_t < aw_t), 1);
      chk("t3_grant_hold", 32'(grant_a), 1);
      chk("t3_s1_wvalid_dropped", 32'(s1a.wvalid), 0);

      // SLVERR read on s1, then the next simultaneous pair starts with s0
      aw_lat = 0;
      rd_resp = 2'b10;
      read_s1(32'h0000_0300, 32'h3333_0300, 2'b10);
      wait_done("t5_err_done", 30);
      rd_resp = 2'b00;
      read_s0(32'h0000_0108, 32'h1111_0108, 2'b00);
      read_s1(32'h0000_0208, 32'h2222_0208, 2'b00);
      wait_done("t5_pair_done", 60);

      // Reset while in RD_DATA with m.rvalid low
      rd_lat = 20;
      read_s0(32'h0000_0400, 32'h4444_0400, 2'b00);
      n = 0;
      while (!ma.rready && n < 30) begin
         tick();
         n++;
      end
      chk("t6_reached_rd_data", 32'(ma.rready), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_busy", 32'(busy_a), 0);
      chk("t6_grant", 32'(grant_a), 0);
      chk("t6_m_arvalid", 32'(ma.arvalid), 0);
      chk("t6_m_rready", 32'(ma.rready), 0);
      chk("t6_s0_rvalid", 32'(s0a.rvalid), 0);
      chk("t6_s0_arready", 32'(s0a.arready), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd_lat = 2;
      tick();
      read_s0(32'h0000_0500, 32'h5555_0500, 2'b00);
      wait_done("t6_fresh_done", 30);
      chk("a_never_both_ports", 32'(both_active), 0);

      // Fixed priority toward port 1 on instance B
      cnt0_b = 0; cnt1_b = 0;
      s0b.araddr = 32'h20;
      s0b.arvalid = 1'b1;
      s1b.arvalid = 1'b1;
      repeat (40) tick();
      chk("fp_s0_starved", 32'(cnt0_b), 0);
      chk("fp_s1_served", 32'(cnt1_b >= 5), 1);
      chk("fp_grant", 32'(grant_b), 1);
      s1b.arvalid = 1'b0;
      repeat (20) tick();
      chk("fp_s0_after_drop", 32'(cnt0_b >= 1), 1);
      s0b.arvalid = 1'b0;
      repeat (5) tick();
      chk("fp_grant_after_drop", 32'(grant_b), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
